// File: rtl/la_clkgate_ctrl.sv
// N-channel automatic clock-gating controller: a per-channel idle-timeout FSM
// drives a latch-based ICG, and the clock is restored on demand after a fixed wake delay.

module la_clkicg #(
  parameter string PROP = "DEFAULT"
) (
  input  logic clk,
  input  logic en,
  input  logic te,
  output logic eclk
);

  logic en_lat;

  if (PROP == "") begin : g_prop_chk
    $error("la_clkicg: PROP must name a cell property");
  end

  // Transparent while clk is low, so the enable can only change outside the high phase.
  always_latch begin
    if (!clk) en_lat <= en | te;
  end

  assign eclk = clk & en_lat;

endmodule

module la_clkgate_ctrl #(
  parameter int unsigned N       = 4,
  parameter int unsigned IDLEW   = 8,
  parameter int unsigned WAKEDLY = 2,
  parameter bit          RSTON   = 1'b1,
  parameter string       PROP    = "DEFAULT"
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             te,
  input  logic [IDLEW-1:0] cfg_idle,
  input  logic [N-1:0]     busy,
  input  logic [N-1:0]     force_on,
  output logic [N-1:0]     eclk,
  output logic [N-1:0]     ready,
  output logic [N-1:0]     gated
);

  typedef enum logic [1:0] {
    ST_ON    = 2'd0,
    ST_COUNT = 2'd1,
    ST_OFF   = 2'd2,
    ST_WAKE  = 2'd3
  } state_e;

  localparam state_e     RST_STATE = RSTON ? ST_ON : ST_OFF;
  localparam logic [3:0] WAKE_LOAD = 4'(WAKEDLY);

  if (N < 1 || WAKEDLY < 1 || WAKEDLY > 15) begin : g_param_chk
    $error("la_clkgate_ctrl: N must be >= 1 and WAKEDLY within 1..15");
  end

  state_e           state_q [N];
  state_e           state_d [N];
  logic [IDLEW-1:0] cnt_q   [N];
  logic [IDLEW-1:0] cnt_d   [N];
  logic [3:0]       wcnt_q  [N];
  logic [3:0]       wcnt_d  [N];
  logic [N-1:0]     en_q, en_d;
  logic [N-1:0]     ready_q, ready_d;
  logic [N-1:0]     gated_q, gated_d;
  logic [N-1:0]     act;

  always_comb begin
    act     = busy | force_on;
    en_d    = '0;
    ready_d = '0;
    gated_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      wcnt_d[i]  = wcnt_q[i];
      case (state_q[i])
        ST_ON: begin
          if (!act[i]) begin
            if (cfg_idle == '0) begin
              state_d[i] = ST_OFF;
            end else begin
              state_d[i] = ST_COUNT;
              cnt_d[i]   = cfg_idle;
            end
          end
        end
        ST_COUNT: begin
          // Activity takes priority over an expiring count.
          if (act[i]) begin
            state_d[i] = ST_ON;
          end else if (cnt_q[i] == IDLEW'(1)) begin
            state_d[i] = ST_OFF;
          end else begin
            cnt_d[i] = cnt_q[i] - IDLEW'(1);
          end
        end
        ST_OFF: begin
          if (act[i]) begin
            state_d[i] = ST_WAKE;
            wcnt_d[i]  = WAKE_LOAD;
          end
        end
        ST_WAKE: begin
          if (wcnt_q[i] == 4'd1) begin
            state_d[i] = ST_ON;
          end else begin
            wcnt_d[i] = wcnt_q[i] - 4'd1;
          end
        end
        default: state_d[i] = RST_STATE;
      endcase
      en_d[i]    = (state_d[i] != ST_OFF);
      ready_d[i] = (state_d[i] == ST_ON) || (state_d[i] == ST_COUNT);
      gated_d[i] = (state_d[i] == ST_OFF);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N; i++) begin
        state_q[i] <= RST_STATE;
        cnt_q[i]   <= '0;
        wcnt_q[i]  <= '0;
      end
      en_q    <= {N{RSTON}};
      ready_q <= {N{RSTON}};
      gated_q <= {N{~RSTON}};
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        wcnt_q[i]  <= wcnt_d[i];
      end
      en_q    <= en_d;
      ready_q <= ready_d;
      gated_q <= gated_d;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_icg
    la_clkicg #(
      .PROP (PROP)
    ) u_icg (
      .clk  (clk),
      .en   (en_q[g]),
      .te   (te),
      .eclk (eclk[g])
    );
  end

  assign ready = ready_q;
  assign gated = gated_q;

endmodule
